// File: rtl/rst_sequencer_if.sv
// Reset-sequencer bundle: per-stage ready inputs and the sequenced reset/status outputs.
//   stage_ready [NUM_STAGES] : subsystem -> sequencer, ready/locked/calibrated per stage
//   stage_rst   [NUM_STAGES] : sequencer -> subsystem, active-high reset per stage
//   seq_done                 : all stages released and acknowledged
//   seq_error                : ready timeout occurred (sticky until rst)
//   cur_stage   [3]          : stage currently being delayed or awaited
// master = sequencer side, slave = subsystem side.
interface rst_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic                  seq_error;
  logic [2:0]            cur_stage;

  modport master (
    input  stage_ready,
    output stage_rst, seq_done, seq_error, cur_stage
  );

  modport slave (
    output stage_ready,
    input  stage_rst, seq_done, seq_error, cur_stage
  );
endinterface

// File: rtl/rst_sequencer.sv
// Ordered reset release: takes the debounced async reset, synchronizes its
// deassertion, then releases each stage's reset in turn after a fixed gap,
// waiting for that stage's ready before moving on.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset (clean_async_rst)
//   bus   : rst_sequencer_if.master (stage_ready in; stage_rst, seq_done,
//           seq_error, cur_stage out -- all outputs registered)
module rst_sequencer #(
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STAGE_DELAY   = 16,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  rst_sequencer_if.master bus
);

  localparam int unsigned MAX_CNT = (STAGE_DELAY > READY_TIMEOUT) ? STAGE_DELAY : READY_TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'((READY_TIMEOUT == 0) ? 0 : READY_TIMEOUT - 1);
  localparam logic [2:0]    LAST_STAGE = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_WAIT_READY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_seq_done;
  logic                  r_seq_error;
  logic [2:0]            r_cur_stage;

  logic                  w_srst;
  logic                  w_cur_ready;
  logic [NUM_STAGES-1:0] w_cur_mask;

  // Deassert synchronizer: async-set by rst, shifts in 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
  end

  assign w_srst = r_sync[SYNC_STAGES-1];

  // Select the current stage's ready bit and build its one-hot mask.
  always_comb begin
    w_cur_ready = 1'b0;
    w_cur_mask  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_cur_stage == 3'(i)) begin
        w_cur_ready   = bus.stage_ready[i];
        w_cur_mask[i] = 1'b1;
      end
    end
  end

  // Sequencing FSM with registered outputs; counter cleared on each state entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stage_rst <= '1;
      r_seq_done  <= 1'b0;
      r_seq_error <= 1'b0;
      r_cur_stage <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_srst) begin
            r_state     <= S_DELAY;
            r_cnt       <= '0;
            r_cur_stage <= 3'd0;
          end
        end
        S_DELAY: begin
          if (r_cnt == DELAY_LAST) begin
            r_stage_rst <= r_stage_rst & ~w_cur_mask;
            r_state     <= S_WAIT_READY;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_READY: begin
          // Ready has priority over a timeout landing on the same edge.
          if (w_cur_ready) begin
            r_cnt <= '0;
            if (r_cur_stage == LAST_STAGE) begin
              r_state    <= S_DONE;
              r_seq_done <= 1'b1;
            end else begin
              r_cur_stage <= r_cur_stage + 3'd1;
              r_state     <= S_DELAY;
            end
          end else if ((READY_TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            r_state     <= S_ERROR;
            r_cnt       <= '0;
            r_stage_rst <= '1;
            r_seq_error <= 1'b1;
          end else if (READY_TIMEOUT != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE, S_ERROR: begin
          // Terminal until rst.
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stage_rst = r_stage_rst;
  assign bus.seq_done  = r_seq_done;
  assign bus.seq_error = r_seq_error;
  assign bus.cur_stage = r_cur_stage;

endmodule
